// File: rtl/mdu_sequencer.sv
// Multi-cycle MIPS-style multiply/divide unit sequencer with HI/LO registers.
// MULT/MULTU take 5 busy cycles, DIV/DIVU take 10; MTHI/MTLO write in a single edge.
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [3:0]  operation,
  input  logic        start,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 4;

  localparam logic [OW-1:0] OP_MULT  = 4'd1;
  localparam logic [OW-1:0] OP_MULTU = 4'd2;
  localparam logic [OW-1:0] OP_DIV   = 4'd3;
  localparam logic [OW-1:0] OP_DIVU  = 4'd4;
  localparam logic [OW-1:0] OP_MTHI  = 4'd5;
  localparam logic [OW-1:0] OP_MTLO  = 4'd6;

  localparam logic [CW-1:0] MUL_CYCLES = 4'd5;
  localparam logic [CW-1:0] DIV_CYCLES = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   op_q, op_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic            is_mul, is_div;
  logic [2*DW-1:0] ext_a, ext_b, prod;
  logic            sdiv, a_neg, b_neg;
  logic [DW-1:0]   ua, ub, ub_safe, uq, ur, quo, rem;

  assign is_mul   = (operation == OP_MULT) || (operation == OP_MULTU);
  assign is_div   = (operation == OP_DIV)  || (operation == OP_DIVU);
  assign occupied = busy_q | (start & (is_mul | is_div));
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Product modulo 2^64 of sign- or zero-extended latched operands.
  always_comb begin
    ext_a = {{DW{1'b0}}, a_q};
    ext_b = {{DW{1'b0}}, b_q};
    if (op_q == OP_MULT) begin
      ext_a = {{DW{a_q[DW-1]}}, a_q};
      ext_b = {{DW{b_q[DW-1]}}, b_q};
    end
    prod = ext_a * ext_b;
  end

  // Sign-magnitude division avoids the INT_MIN / -1 overflow case entirely.
  always_comb begin
    sdiv    = (op_q == OP_DIV);
    a_neg   = sdiv & a_q[DW-1];
    b_neg   = sdiv & b_q[DW-1];
    ua      = a_neg ? (~a_q + DW'(1)) : a_q;
    ub      = b_neg ? (~b_q + DW'(1)) : b_q;
    ub_safe = (ub == '0) ? DW'(1) : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    quo     = (a_neg ^ b_neg) ? (~uq + DW'(1)) : uq;
    rem     = a_neg ? (~ur + DW'(1)) : ur;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? ST_MUL : ST_DIV;
            busy_d  = 1'b1;
            cnt_d   = is_mul ? MUL_CYCLES : DIV_CYCLES;
            op_d    = operation;
            a_d     = operand1;
            b_d     = operand2;
          end else if (operation == OP_MTHI) begin
            hi_d = operand1;
          end else if (operation == OP_MTLO) begin
            lo_d = operand1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (state_q == ST_MUL) begin
            hi_d = prod[2*DW-1:DW];
            lo_d = prod[DW-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
